// File: rtl/operand_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry_if
//  Brief    : Keypad/ALU handshake bundle for the calculator operand entry
//             block. The slave side is the operand_entry block itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface operand_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_res;
    logic        alu_valid;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        op;
    logic        start;
    logic [15:0] disp;
    logic [1:0]  state;

    modport master (
        output key_valid, key_code, alu_res, alu_valid,
        input  num1, num2, op, start, disp, state
    );

    modport slave (
        input  key_valid, key_code, alu_res, alu_valid,
        output num1, num2, op, start, disp, state
    );
endinterface
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry
//  Brief    : Calculator operand entry FSM. Collects two BCD operands and an
//             add/subtract operator from keypad events, requests an ALU
//             evaluation, captures the result and supports result chaining.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_entry #(
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_entry_if.slave   bus
);

    typedef enum logic [1:0] {
        ENTER_A  = 2'b00,
        ENTER_B  = 2'b01,
        WAIT_RES = 2'b10,
        SHOW     = 2'b11
    } state_t;

    localparam logic [2:0] C_MAX   = 3'(MAX_DIGITS);
    localparam logic [3:0] C_PLUS  = 4'hA;
    localparam logic [3:0] C_MINUS = 4'hB;
    localparam logic [3:0] C_CLEAR = 4'hC;
    localparam logic [3:0] C_EQ    = 4'hE;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  cnt_a_q, cnt_a_d;
    logic [2:0]  cnt_b_q, cnt_b_d;
    logic        op_q, op_d;
    logic        start_q, start_d;
    logic [15:0] res_q, res_d;

    logic w_digit;
    logic w_oper;
    logic w_clear;
    logic w_equals;

    // Key decode; everything is qualified by key_valid so stray codes do nothing
    always_comb begin
        w_digit  = bus.key_valid && (bus.key_code <= 4'h9);
        w_oper   = bus.key_valid && ((bus.key_code == C_PLUS) || (bus.key_code == C_MINUS));
        w_clear  = bus.key_valid && (bus.key_code == C_CLEAR);
        w_equals = bus.key_valid && (bus.key_code == C_EQ);
    end

    // Next-state logic: per-state key handling, with clear overriding everything
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        start_d = 1'b0;
        res_d   = res_q;

        case (state_q)
            ENTER_A: begin
                if (w_digit) begin
                    if (cnt_a_q != C_MAX) begin
                        a_d     = {a_q[11:0], bus.key_code};
                        cnt_a_d = cnt_a_q + 3'd1;
                    end
                end else if (w_oper) begin
                    op_d    = (bus.key_code == C_MINUS);
                    b_d     = 16'h0000;
                    cnt_b_d = 3'd0;
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                if (w_digit) begin
                    if (cnt_b_q != C_MAX) begin
                        b_d     = {b_q[11:0], bus.key_code};
                        cnt_b_d = cnt_b_q + 3'd1;
                    end
                end else if (w_oper) begin
                    // Operator may only be changed before B has any digits
                    if (cnt_b_q == 3'd0) begin
                        op_d = (bus.key_code == C_MINUS);
                    end
                end else if (w_equals) begin
                    start_d = 1'b1;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // alu_valid during the start cycle still reflects a stale result
                if (bus.alu_valid && !start_q) begin
                    res_d   = bus.alu_res;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (w_digit) begin
                    a_d     = {12'h000, bus.key_code};
                    cnt_a_d = 3'd1;
                    b_d     = 16'h0000;
                    cnt_b_d = 3'd0;
                    state_d = ENTER_A;
                end else if (w_oper) begin
                    // Chaining: the result becomes operand A, treated as full
                    a_d     = res_q;
                    cnt_a_d = C_MAX;
                    op_d    = (bus.key_code == C_MINUS);
                    b_d     = 16'h0000;
                    cnt_b_d = 3'd0;
                    state_d = ENTER_B;
                end
            end
            default: state_d = ENTER_A;
        endcase

        if (w_clear) begin
            state_d = ENTER_A;
            a_d     = 16'h0000;
            b_d     = 16'h0000;
            cnt_a_d = 3'd0;
            cnt_b_d = 3'd0;
            op_d    = 1'b0;
            start_d = 1'b0;
            res_d   = 16'h0000;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            cnt_a_q <= 3'd0;
            cnt_b_q <= 3'd0;
            op_q    <= 1'b0;
            start_q <= 1'b0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            op_q    <= op_d;
            start_q <= start_d;
            res_q   <= res_d;
        end
    end

    // Display mux: the operand being entered, or the captured result
    always_comb begin
        case (state_q)
            ENTER_A: bus.disp = a_q;
            SHOW:    bus.disp = res_q;
            default: bus.disp = b_q;
        endcase
    end

    assign bus.num1  = a_q;
    assign bus.num2  = b_q;
    assign bus.op    = op_q;
    assign bus.start = start_q;
    assign bus.state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_entry
//  Brief    : Self-checking bench for operand_entry: directed scenarios plus
//             randomized keypad/ALU traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

    localparam int MAXD = 4;
    localparam logic [3:0] K_PLUS = 4'hA, K_MINUS = 4'hB, K_CLR = 4'hC, K_EQ = 4'hE;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    operand_entry_if bus ();

    operand_entry #(.MAX_DIGITS(MAXD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model of the calculator front end
    logic [1:0]  m_state;   // 0 enter A, 1 enter B, 2 wait, 3 show
    int          m_a, m_b, m_ca, m_cb, m_res;
    logic        m_op, m_start;

    function automatic void model_clear();
        m_state = 2'd0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
        m_res = 0; m_op = 1'b0; m_start = 1'b0;
    endfunction

    function automatic void model_edge(input logic rst, input logic kv, input logic [3:0] kc,
                                       input logic av, input logic [15:0] ar);
        logic was_start;
        bit   is_dig, is_op;
        was_start = m_start;
        m_start   = 1'b0;
        is_dig    = kv && (kc < 10);
        is_op     = kv && (kc == K_PLUS || kc == K_MINUS);
        if (!rst || (kv && kc == K_CLR)) begin
            model_clear();
            return;
        end
        if (m_state == 2'd0) begin
            if (is_dig && m_ca < MAXD) begin m_a = (m_a * 16 + kc) % 65536; m_ca++; end
            else if (is_op) begin m_op = (kc == K_MINUS); m_b = 0; m_cb = 0; m_state = 2'd1; end
        end else if (m_state == 2'd1) begin
            if (is_dig && m_cb < MAXD) begin m_b = (m_b * 16 + kc) % 65536; m_cb++; end
            else if (is_op && m_cb == 0) m_op = (kc == K_MINUS);
            else if (kv && kc == K_EQ) begin m_start = 1'b1; m_state = 2'd2; end
        end else if (m_state == 2'd2) begin
            if (av && !was_start) begin m_res = ar; m_state = 2'd3; end
        end else begin
            if (is_dig) begin m_a = kc; m_ca = 1; m_b = 0; m_cb = 0; m_state = 2'd0; end
            else if (is_op) begin
                m_a = m_res; m_ca = MAXD; m_op = (kc == K_MINUS);
                m_b = 0; m_cb = 0; m_state = 2'd1;
            end
        end
    endfunction

    // One clock of stimulus; inputs change on the falling edge, model follows the rising edge
    task automatic step(input logic rst, input logic kv, input logic [3:0] kc,
                        input logic av, input logic [15:0] ar);
        @(negedge clk);
        rst_n = rst; bus.key_valid = kv; bus.key_code = kc;
        bus.alu_valid = av; bus.alu_res = ar;
        @(posedge clk);
        model_edge(rst, kv, kc, av, ar);
        #1;
    endtask

    task automatic press(input logic [3:0] kc);
        step(1'b1, 1'b1, kc, 1'b0, 16'h0000);
    endtask

    task automatic alu(input logic [15:0] r);
        step(1'b1, 1'b0, 4'h0, 1'b1, r);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000);
        n_vec++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b expected 00", bus.state); end
        n_vec++; if (bus.num1 !== 16'h0000) begin n_err++; $display("FAIL reset_num1: got %h expected 0000", bus.num1); end
        n_vec++; if (bus.num2 !== 16'h0000) begin n_err++; $display("FAIL reset_num2: got %h expected 0000", bus.num2); end
        n_vec++; if (bus.op !== 1'b0) begin n_err++; $display("FAIL reset_op: got %b expected 0", bus.op); end
        n_vec++; if (bus.start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b expected 0", bus.start); end
        n_vec++; if (bus.disp !== 16'h0000) begin n_err++; $display("FAIL reset_disp: got %h expected 0000", bus.disp); end
    endtask

    task automatic test_basic();
        press(4'h1); press(4'h2); press(4'h3);
        n_vec++; if (bus.disp !== 16'h0123) begin n_err++; $display("FAIL basic_dispA: got %h expected 0123", bus.disp); end
        press(K_PLUS); press(4'h4); press(4'h5);
        n_vec++; if (bus.disp !== 16'h0045) begin n_err++; $display("FAIL basic_dispB: got %h expected 0045", bus.disp); end
        press(K_EQ);
        n_vec++; if (bus.num1 !== 16'h0123) begin n_err++; $display("FAIL basic_num1: got %h expected 0123", bus.num1); end
        n_vec++; if (bus.num2 !== 16'h0045) begin n_err++; $display("FAIL basic_num2: got %h expected 0045", bus.num2); end
        n_vec++; if (bus.op !== 1'b0) begin n_err++; $display("FAIL basic_op: got %b expected 0", bus.op); end
        n_vec++; if (bus.start !== 1'b1) begin n_err++; $display("FAIL basic_start: got %b expected 1", bus.start); end
        n_vec++; if (bus.state !== 2'b10) begin n_err++; $display("FAIL basic_wait: got %b expected 10", bus.state); end
        // alu_valid in the start cycle must be ignored
        alu(16'h9999);
        n_vec++; if (bus.state !== 2'b10) begin n_err++; $display("FAIL basic_early_valid: got state %b expected 10", bus.state); end
        n_vec++; if (bus.start !== 1'b0) begin n_err++; $display("FAIL basic_start_once: got %b expected 0", bus.start); end
        press(4'h7);  // digits ignored while waiting
        n_vec++; if (bus.num1 !== 16'h0123 || bus.num2 !== 16'h0045) begin n_err++; $display("FAIL basic_hold: got %h/%h expected 0123/0045", bus.num1, bus.num2); end
        alu(16'h0168);
        n_vec++; if (bus.state !== 2'b11) begin n_err++; $display("FAIL basic_show: got %b expected 11", bus.state); end
        n_vec++; if (bus.disp !== 16'h0168) begin n_err++; $display("FAIL basic_result: got %h expected 0168", bus.disp); end
        press(K_EQ);
        n_vec++; if (bus.state !== 2'b11) begin n_err++; $display("FAIL show_eq_ignored: got %b expected 11", bus.state); end
    endtask

    task automatic test_chain();
        press(K_PLUS); press(4'h2); press(K_EQ);
        n_vec++; if (bus.num1 !== 16'h0168) begin n_err++; $display("FAIL chain_num1: got %h expected 0168", bus.num1); end
        n_vec++; if (bus.num2 !== 16'h0002) begin n_err++; $display("FAIL chain_num2: got %h expected 0002", bus.num2); end
        n_vec++; if (bus.op !== 1'b0) begin n_err++; $display("FAIL chain_op: got %b expected 0", bus.op); end
        n_vec++; if (bus.start !== 1'b1) begin n_err++; $display("FAIL chain_start: got %b expected 1", bus.start); end
        step(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000);
        n_vec++; if (bus.start !== 1'b0) begin n_err++; $display("FAIL chain_start_once: got %b expected 0", bus.start); end
        alu(16'h0170);
        press(4'h7);
        n_vec++; if (bus.state !== 2'b00 || bus.num1 !== 16'h0007 || bus.num2 !== 16'h0000) begin n_err++; $display("FAIL show_digit: got st %b A %h B %h expected 00/0007/0000", bus.state, bus.num1, bus.num2); end
    endtask

    task automatic test_overflow();
        press(K_CLR);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        n_vec++; if (bus.num1 !== 16'h1234) begin n_err++; $display("FAIL overflow_num1: got %h expected 1234", bus.num1); end
        press(4'hD); press(4'hF); press(K_EQ);
        step(1'b1, 1'b0, 4'h6, 1'b1, 16'h4321);
        n_vec++; if (bus.state !== 2'b00 || bus.disp !== 16'h1234) begin n_err++; $display("FAIL ignored_keys: got st %b disp %h expected 00/1234", bus.state, bus.disp); end
    endtask

    task automatic test_op_overwrite();
        press(K_CLR);
        press(4'h9); press(K_MINUS); press(K_PLUS); press(4'h7); press(K_EQ);
        n_vec++; if (bus.op !== 1'b0 || bus.num2 !== 16'h0007) begin n_err++; $display("FAIL op_overwrite: got op %b B %h expected 0/0007", bus.op, bus.num2); end
        press(K_CLR);
        press(4'h9); press(K_MINUS); press(4'h7); press(K_PLUS); press(4'h2);
        n_vec++; if (bus.op !== 1'b1) begin n_err++; $display("FAIL op_locked: got %b expected 1", bus.op); end
        n_vec++; if (bus.num2 !== 16'h0072 || bus.state !== 2'b01) begin n_err++; $display("FAIL op_locked_b: got B %h st %b expected 0072/01", bus.num2, bus.state); end
    endtask

    task automatic test_clear_wait();
        press(K_CLR);
        press(4'h5); press(K_PLUS); press(4'h3); press(K_EQ);
        step(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, K_CLR, 1'b1, 16'h0008);
        n_vec++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL clear_wait_state: got %b expected 00", bus.state); end
        n_vec++; if (bus.num1 !== 16'h0000 || bus.num2 !== 16'h0000 || bus.op !== 1'b0 || bus.disp !== 16'h0000) begin n_err++; $display("FAIL clear_wait_zero: got %h/%h/%b/%h expected zeros", bus.num1, bus.num2, bus.op, bus.disp); end
    endtask

    task automatic test_reset_enter_b();
        press(4'h1); press(K_MINUS); press(4'h2);
        step(1'b0, 1'b1, 4'h3, 1'b1, 16'h1111);
        n_vec++; if (bus.state !== 2'b00 || bus.num1 !== 16'h0000 || bus.num2 !== 16'h0000) begin n_err++; $display("FAIL reset_b: got st %b A %h B %h expected 00/0000/0000", bus.state, bus.num1, bus.num2); end
        n_vec++; if (bus.op !== 1'b0 || bus.start !== 1'b0 || bus.disp !== 16'h0000) begin n_err++; $display("FAIL reset_b_out: got op %b start %b disp %h expected 0/0/0000", bus.op, bus.start, bus.disp); end
    endtask

    task automatic test_random();
        logic        rst, kv, av;
        logic [3:0]  kc;
        logic [15:0] ar;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            kv  = ($urandom_range(0, 1) == 1);
            kc  = 4'($urandom_range(0, 15));
            av  = ($urandom_range(0, 3) == 0);
            ar  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            step(rst, kv, kc, av, ar);
            n_vec++; if (bus.state !== m_state) begin n_err++; $display("FAIL rnd_state@%0d: got %b expected %b", i, bus.state, m_state); end
            n_vec++; if (bus.num1 !== 16'(m_a) || bus.num2 !== 16'(m_b)) begin n_err++; $display("FAIL rnd_nums@%0d: got %h/%h expected %h/%h", i, bus.num1, bus.num2, 16'(m_a), 16'(m_b)); end
            n_vec++; if (bus.op !== m_op || bus.start !== m_start) begin n_err++; $display("FAIL rnd_op_start@%0d: got %b/%b expected %b/%b", i, bus.op, bus.start, m_op, m_start); end
            if (m_state != 2'd2) begin
                n_vec++;
                if (bus.disp !== ((m_state == 2'd0) ? 16'(m_a) : (m_state == 2'd1) ? 16'(m_b) : 16'(m_res))) begin
                    n_err++; $display("FAIL rnd_disp@%0d: got %h in state %b", i, bus.disp, m_state);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_valid = 1'b0; bus.key_code = 4'h0;
        bus.alu_valid = 1'b0; bus.alu_res = 16'h0000;
        model_clear();
        test_reset();
        test_basic();
        test_chain();
        test_overflow();
        test_op_overwrite();
        test_clear_wait();
        test_reset_enter_b();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
